trap_sequencer: RTL and testbench

Sequences machine-mode trap entry and `mret` return for the single-hart RV32 core. It sits between the decode/execute stage and the CSR unit. It collects synchronous exception flags from the datapath and the timer interrupt request from the CSR unit. It then drives the CSR unit's trap-capture inputs (`jumpingToMtvec`, cause, trap info, PC) and redirects fetch to `mtvec` or `mepc`.

---
 rtl/riscV_unrn_pkg.sv | 29 ++
 rtl/trap_priority_enc.sv | 71 +++++++
 rtl/trap_sequencer.sv | 154 +++++++++++++++
 tb/tb_trap_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscV_unrn_pkg.sv
// Shared types and constants for the trap sequencer.
// Provides the datapath width, the trap FSM state encoding, the mcause
// values produced by trap entry, and a helper that aligns mtvec to a
// direct-mode handler address.
package riscV_unrn_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAP   = 2'd1,
    VECTOR = 2'd2,
    RET    = 2'd3
  } trap_state_t;

  localparam logic [XLEN-1:0] CAUSE_FETCH_MISAL = XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL     = XLEN'(32'h0000_0002);
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT  = XLEN'(32'h0000_0003);
  localparam logic [XLEN-1:0] CAUSE_LOAD_MISAL  = XLEN'(32'h0000_0004);
  localparam logic [XLEN-1:0] CAUSE_STORE_MISAL = XLEN'(32'h0000_0006);
  localparam logic [XLEN-1:0] CAUSE_ECALL_M     = XLEN'(32'h0000_000B);
  localparam logic [XLEN-1:0] CAUSE_MTIME_INT   = XLEN'(32'h8000_0007);

  // Direct-mode vector: the low two mtvec bits hold the mode, not address.
  function automatic logic [XLEN-1:0] vec_base(input logic [XLEN-1:0] mtvec);
    return {mtvec[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational trap priority encoder.
// Picks the highest-priority pending trap and forms its mcause / mtval.
// Ports: flags (mtime, fetch/load/store misalignment, illegal, ecall,
//   ebreak), pc_i, instr_i, badaddr_i in; trap_o, cause_o, info_o out.
// Macro TRAP_MISALIGNED_EN: when undefined the misalignment flags are
//   ignored and causes 0/4/6 are never produced.
module trap_priority_enc
  import riscV_unrn_pkg::*;
(
  input  logic            mtime_exc_i,
  input  logic            fetch_misal_i,
  input  logic            illegal_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            load_misal_i,
  input  logic            store_misal_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] badaddr_i,
  output logic            trap_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] info_o
);

  logic fetch_m;
  logic load_m;
  logic store_m;

`ifdef TRAP_MISALIGNED_EN
  assign fetch_m = fetch_misal_i;
  assign load_m  = load_misal_i;
  assign store_m = store_misal_i;
`else
  // Misalignment is handled elsewhere in this build; flags are dropped.
  logic unused_misal;
  assign unused_misal = fetch_misal_i ^ load_misal_i ^ store_misal_i;
  assign fetch_m = 1'b0;
  assign load_m  = 1'b0;
  assign store_m = 1'b0;
`endif

  // Fixed priority, highest first.
  always_comb begin
    trap_o  = 1'b1;
    cause_o = '0;
    info_o  = '0;
    if (mtime_exc_i) begin
      cause_o = CAUSE_MTIME_INT;
    end else if (fetch_m) begin
      cause_o = CAUSE_FETCH_MISAL;
      info_o  = badaddr_i;
    end else if (illegal_i) begin
      cause_o = CAUSE_ILLEGAL;
      info_o  = instr_i;
    end else if (ecall_i) begin
      cause_o = CAUSE_ECALL_M;
    end else if (ebreak_i) begin
      cause_o = CAUSE_BREAKPOINT;
      info_o  = pc_i;
    end else if (load_m) begin
      cause_o = CAUSE_LOAD_MISAL;
      info_o  = badaddr_i;
    end else if (store_m) begin
      cause_o = CAUSE_STORE_MISAL;
      info_o  = badaddr_i;
    end else begin
      trap_o = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret return sequencer.
// Detects traps at the commit point, drives the CSR capture strobe with
// cause/info/pc, then redirects fetch to mtvec; mret redirects to mepc.
// Ports: clk, rst_n; instr_valid_i, pc_i, instr_i, badaddr_i, decode and
//   misalignment flags, mtime_exc_i, mtvec_i, mepc_i in; kill_o, stall_o,
//   jumpingToMtvec_o, excCause_o, trapInfo_o, trap_pc_o, pc_redirect_o,
//   pc_target_o, mret_o out.
// Macro TRAP_MISALIGNED_EN: enables the misalignment traps (see encoder).
module trap_sequencer
  import riscV_unrn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] badaddr_i,
  input  logic            illegal_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            fetch_misal_i,
  input  logic            load_misal_i,
  input  logic            store_misal_i,
  input  logic            mtime_exc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            kill_o,
  output logic            stall_o,
  output logic            jumpingToMtvec_o,
  output logic [XLEN-1:0] excCause_o,
  output logic [XLEN-1:0] trapInfo_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic            pc_redirect_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            mret_o
);

  trap_state_t     state_q, state_d;
  logic            armed_q;
  logic [XLEN-1:0] cause_q, info_q, tpc_q;

  logic            enc_trap;
  logic [XLEN-1:0] enc_cause, enc_info;
  logic            detect_en;
  logic            take_trap;
  logic            take_mret;

  trap_priority_enc u_enc (
    .mtime_exc_i   (mtime_exc_i),
    .fetch_misal_i (fetch_misal_i),
    .illegal_i     (illegal_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .load_misal_i  (load_misal_i),
    .store_misal_i (store_misal_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .badaddr_i     (badaddr_i),
    .trap_o        (enc_trap),
    .cause_o       (enc_cause),
    .info_o        (enc_info)
  );

  // armed_q holds off detection until the first edge after reset release,
  // so nothing is detected (or killed) while reset is asserted.
  assign detect_en = armed_q && instr_valid_i && (state_q == IDLE);
  assign take_trap = detect_en && enc_trap;
  assign take_mret = detect_en && !enc_trap && mret_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Trap capture registers, loaded on detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
      info_q  <= '0;
      tpc_q   <= '0;
    end else if (take_trap) begin
      cause_q <= enc_cause;
      info_q  <= enc_info;
      tpc_q   <= pc_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          state_d = TRAP;
        end else if (take_mret) begin
          state_d = RET;
        end
      end
      TRAP:    state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; kill/stall on detection are same-cycle by design
  always_comb begin
    kill_o           = 1'b0;
    stall_o          = 1'b0;
    jumpingToMtvec_o = 1'b0;
    excCause_o       = '0;
    trapInfo_o       = '0;
    trap_pc_o        = '0;
    pc_redirect_o    = 1'b0;
    pc_target_o      = '0;
    mret_o           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          kill_o  = 1'b1;
          stall_o = 1'b1;
        end else if (take_mret) begin
          stall_o = 1'b1;
        end
      end
      TRAP: begin
        jumpingToMtvec_o = 1'b1;
        stall_o          = 1'b1;
        excCause_o       = cause_q;
        trapInfo_o       = info_q;
        trap_pc_o        = tpc_q;
      end
      VECTOR: begin
        stall_o       = 1'b1;
        pc_redirect_o = 1'b1;
        pc_target_o   = vec_base(mtvec_i);
      end
      RET: begin
        pc_redirect_o = 1'b1;
        pc_target_o   = mepc_i;
        mret_o        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes expected strobe /
// redirect events, a negedge monitor pops and compares them.
module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid_i;
  logic [31:0] pc_i, instr_i, badaddr_i;
  logic        illegal_i, ecall_i, ebreak_i, mret_i;
  logic        fetch_misal_i, load_misal_i, store_misal_i, mtime_exc_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        kill_o, stall_o, jumpingToMtvec_o, pc_redirect_o, mret_o;
  logic [31:0] excCause_o, trapInfo_o, trap_pc_o, pc_target_o;

  trap_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid_i    (instr_valid_i),
    .pc_i             (pc_i),
    .instr_i          (instr_i),
    .badaddr_i        (badaddr_i),
    .illegal_i        (illegal_i),
    .ecall_i          (ecall_i),
    .ebreak_i         (ebreak_i),
    .mret_i           (mret_i),
    .fetch_misal_i    (fetch_misal_i),
    .load_misal_i     (load_misal_i),
    .store_misal_i    (store_misal_i),
    .mtime_exc_i      (mtime_exc_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .kill_o           (kill_o),
    .stall_o          (stall_o),
    .jumpingToMtvec_o (jumpingToMtvec_o),
    .excCause_o       (excCause_o),
    .trapInfo_o       (trapInfo_o),
    .trap_pc_o        (trap_pc_o),
    .pc_redirect_o    (pc_redirect_o),
    .pc_target_o      (pc_target_o),
    .mret_o           (mret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          strobe;  // 1: capture strobe, 0: PC redirect
    logic [31:0] a;       // cause, or redirect target
    logic [31:0] b;       // info
    logic [31:0] c;       // trap pc
    bit          is_mret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] info,
                           input logic [31:0] pc, input logic [31:0] target);
    exp_t e;
    e = '{strobe: 1'b1, a: cause, b: info, c: pc, is_mret: 1'b0};
    exp_q.push_back(e);
    e = '{strobe: 1'b0, a: target, b: 32'h0, c: 32'h0, is_mret: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] target);
    exp_t e;
    e = '{strobe: 1'b0, a: target, b: 32'h0, c: 32'h0, is_mret: 1'b1};
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or redirect must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (jumpingToMtvec_o || pc_redirect_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: strobe=%0b redirect=%0b target=%h, expected none",
                 jumpingToMtvec_o, pc_redirect_o, pc_target_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.strobe) begin
          chk("strobe", 32'(jumpingToMtvec_o), 32'd1);
          chk("strobe_no_redirect", 32'(pc_redirect_o), 32'd0);
          chk("strobe_stall", 32'(stall_o), 32'd1);
          chk("excCause", excCause_o, e.a);
          chk("trapInfo", trapInfo_o, e.b);
          chk("trap_pc", trap_pc_o, e.c);
        end else begin
          chk("redirect", 32'(pc_redirect_o), 32'd1);
          chk("redirect_no_strobe", 32'(jumpingToMtvec_o), 32'd0);
          chk("pc_target", pc_target_o, e.a);
          chk("mret_o", 32'(mret_o), 32'(e.is_mret));
          if (!e.is_mret) chk("vector_stall", 32'(stall_o), 32'd1);
        end
      end
    end
  end

  task automatic clear_inputs();
    instr_valid_i = 1'b0;
    illegal_i = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    fetch_misal_i = 1'b0; load_misal_i = 1'b0; store_misal_i = 1'b0;
    mtime_exc_i = 1'b0;
    pc_i = '0; instr_i = '0; badaddr_i = '0;
  endtask

  // flags = {mtime, fetch, illegal, ecall, ebreak, load, store, mret}
  task automatic commit(input string name, input logic valid, input logic [7:0] flags,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] badaddr, input logic exp_kill,
                        input logic exp_stall);
    @(posedge clk); #1;
    instr_valid_i = valid;
    {mtime_exc_i, fetch_misal_i, illegal_i, ecall_i, ebreak_i,
     load_misal_i, store_misal_i, mret_i} = flags;
    pc_i = pc; instr_i = instr; badaddr_i = badaddr;
    #1;
    chk({name, "_kill"}, 32'(kill_o), 32'(exp_kill));
    chk({name, "_stall"}, 32'(stall_o), 32'(exp_stall));
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_cause0"}, excCause_o, 32'h0);
    chk({name, "_info0"}, trapInfo_o, 32'h0);
    chk({name, "_tpc0"}, trap_pc_o, 32'h0);
    chk({name, "_target0"}, pc_target_o, 32'h0);
    chk({name, "_ctrl0"},
        32'({kill_o, stall_o, jumpingToMtvec_o, pc_redirect_o, mret_o}), 32'h0);
  endtask

  localparam logic [7:0] F_MTIME   = 8'b1000_0000;
  localparam logic [7:0] F_ILLEGAL = 8'b0010_0000;
  localparam logic [7:0] F_ECALL   = 8'b0001_0000;
  localparam logic [7:0] F_EBREAK  = 8'b0000_1000;
  localparam logic [7:0] F_LOAD    = 8'b0000_0100;
  localparam logic [7:0] F_MRET    = 8'b0000_0001;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    mtvec_i = 32'h0000_0201;
    mepc_i  = 32'h0000_0104;
    #2;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ecall at 0x100, mtvec 0x201 -> vector 0x200
    push_trap(32'd11, 32'h0, 32'h100, 32'h200);
    commit("ecall", 1'b1, F_ECALL, 32'h100, 32'h0000_0073, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 check_quiet("idle_after_ecall");

    // illegal instruction
    push_trap(32'd2, 32'hFFFF_FFFF, 32'h200, 32'h200);
    commit("illegal", 1'b1, F_ILLEGAL, 32'h200, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);

    // interrupt beats ecall
    push_trap(32'h8000_0007, 32'h0, 32'h40, 32'h200);
    commit("mtime_ecall", 1'b1, F_MTIME | F_ECALL, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);

    // mret: stall only, then redirect to mepc with mret pulse
    push_mret(32'h104);
    commit("mret", 1'b1, F_MRET, 32'h300, 32'h3020_0073, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // ebreak: info is pc
    push_trap(32'd3, 32'h300, 32'h300, 32'h200);
    commit("ebreak", 1'b1, F_EBREAK, 32'h300, 32'h0010_0073, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);

    // interrupt with mret: trap wins, mret not performed
    push_trap(32'h8000_0007, 32'h0, 32'h44, 32'h200);
    commit("mtime_mret", 1'b1, F_MTIME | F_MRET, 32'h44, 32'h3020_0073, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);

    // load misaligned depends on build option
`ifdef TRAP_MISALIGNED_EN
    push_trap(32'd4, 32'h1003, 32'h500, 32'h200);
    commit("load_misal", 1'b1, F_LOAD, 32'h500, 32'h0, 32'h1003, 1'b1, 1'b1);
`else
    commit("load_misal", 1'b1, F_LOAD, 32'h500, 32'h0, 32'h1003, 1'b0, 1'b0);
`endif
    repeat (3) @(posedge clk);

    // flags without instr_valid are ignored
    commit("novalid", 1'b0, F_ECALL, 32'h520, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    // second trap arriving in VECTOR is ignored
    push_trap(32'd11, 32'h0, 32'h540, 32'h200);
    commit("ecall_b2b", 1'b1, F_ECALL, 32'h540, 32'h0, 32'h0, 1'b1, 1'b1);
    commit("illegal_in_vector", 1'b1, F_ILLEGAL, 32'h544, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // reset during TRAP: outputs drop immediately, no strobe afterwards
    commit("ecall_pre_reset", 1'b1, F_ECALL, 32'h700, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("trap_state_strobe", 32'(jumpingToMtvec_o), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_quiet("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_quiet("after_release");
    repeat (2) @(posedge clk);

    push_trap(32'd11, 32'h0, 32'h600, 32'h200);
    commit("ecall_after_reset", 1'b1, F_ECALL, 32'h600, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);

    // every expected event must have been observed
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
